ball_trajectory: RTL and testbench

Per-frame projectile engine that produces the ball's screen position for the pixel generator. A shot is loaded through a valid/ready launch handshake. On each frame tick (start of vertical blanking from the sync generator), the block applies gravity, floor bounces and side-wall reflections. Outputs change only during blanking, so the pixel generator never sees tearing.

---
 rtl/trajectory_pkg.sv | 30 +++
 rtl/trajectory_step.sv | 71 +++++++
 rtl/ball_trajectory.sv | 146 ++++++++++++++
 tb/tb_ball_trajectory.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/trajectory_pkg.sv
// Shared constants and FSM state type for the ball trajectory engine.
// Positions are unsigned 10.FRAC fixed point; velocities are signed 1/16 px/frame.
package trajectory_pkg;

  localparam int FRAC        = 4;
  localparam int GRAVITY     = 6;
  localparam int BALL_R      = 4;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int X_MAX       = SCREEN_W - 1;
  localparam int FLOOR_Y     = 470;
  localparam int DAMP_SHIFT  = 1;
  localparam int MAX_BOUNCES = 3;

  localparam int PosW = 10 + FRAC;
  localparam int VelW = 12;
  localparam int SumW = 16;

  localparam int FloorC = FLOOR_Y - BALL_R;
  localparam int RightC = X_MAX - BALL_R;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StUpdate,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/trajectory_step.sv
// Combinational per-frame maths: gravity with saturation, position sums, and
// floor/wall/ceiling resolution of the registered sums.
module trajectory_step
  import trajectory_pkg::*;
(
  input  logic        [PosW-1:0] px_i,
  input  logic        [PosW-1:0] py_i,
  input  logic signed [VelW-1:0] vx_i,
  input  logic signed [VelW-1:0] vy_i,
  output logic signed [VelW-1:0] vy_grav_o,
  output logic signed [SumW-1:0] px_sum_o,
  output logic signed [SumW-1:0] py_sum_o,
  input  logic signed [SumW-1:0] px_chk_i,
  input  logic signed [SumW-1:0] py_chk_i,
  input  logic signed [VelW-1:0] vx_chk_i,
  input  logic signed [VelW-1:0] vy_chk_i,
  input  logic        [1:0]      bounce_i,
  output logic        [PosW-1:0] px_res_o,
  output logic        [PosW-1:0] py_res_o,
  output logic signed [VelW-1:0] vx_res_o,
  output logic signed [VelW-1:0] vy_res_o,
  output logic        [1:0]      bounce_res_o
);

  logic        [VelW:0]   vy_ext;
  logic signed [SumW-1:0] px_int;
  logic signed [SumW-1:0] py_int;
  logic signed [VelW-1:0] vx_abs;

  always_comb begin
    vy_ext = {vy_i[VelW-1], vy_i} + (VelW+1)'(GRAVITY);
    if (vy_ext[VelW] != vy_ext[VelW-1]) begin
      vy_grav_o = vy_ext[VelW] ? {1'b1, {(VelW-1){1'b0}}} : {1'b0, {(VelW-1){1'b1}}};
    end else begin
      vy_grav_o = vy_ext[VelW-1:0];
    end
    px_sum_o = $signed({{(SumW-PosW){1'b0}}, px_i}) +
               $signed({{(SumW-VelW){vx_i[VelW-1]}}, vx_i});
    py_sum_o = $signed({{(SumW-PosW){1'b0}}, py_i}) +
               $signed({{(SumW-VelW){vy_grav_o[VelW-1]}}, vy_grav_o});
  end

  always_comb begin
    px_int       = px_chk_i >>> FRAC;
    py_int       = py_chk_i >>> FRAC;
    vx_abs       = vx_chk_i[VelW-1] ? -vx_chk_i : vx_chk_i;
    px_res_o     = px_chk_i[PosW-1:0];
    py_res_o     = py_chk_i[PosW-1:0];
    vx_res_o     = vx_chk_i;
    vy_res_o     = vy_chk_i;
    bounce_res_o = bounce_i;

    // Floor only counts when moving down, so a ball resting on it cannot re-bounce.
    if (py_int >= FloorC && vy_chk_i > 0) begin
      py_res_o     = PosW'(FloorC << FRAC);
      vy_res_o     = -(vy_chk_i >>> DAMP_SHIFT);
      bounce_res_o = 2'(bounce_i + 2'd1);
    end else if (py_chk_i < 0) begin
      py_res_o = '0;
    end

    if (px_int <= BALL_R) begin
      px_res_o = PosW'(BALL_R << FRAC);
      vx_res_o = vx_abs;
    end else if (px_int >= RightC) begin
      px_res_o = PosW'(RightC << FRAC);
      vx_res_o = -vx_abs;
    end
  end

endmodule

// File: rtl/ball_trajectory.sv
// Frame-synchronous projectile engine: launch handshake, per-tick update and
// collision check, with screen outputs latched only inside vertical blanking.
module ball_trajectory
  import trajectory_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       launch_valid_i,
  output logic       launch_ready_o,
  input  logic [9:0] launch_x_i,
  input  logic [9:0] launch_y_i,
  input  logic [7:0] launch_vx_i,
  input  logic [7:0] launch_vy_i,
  input  logic       abort_i,
  output logic [9:0] ball_x_o,
  output logic [9:0] ball_y_o,
  output logic       ball_active_o,
  output logic [1:0] bounce_count_o,
  output logic       shot_done_o
);

  state_e                 state_q;
  logic        [PosW-1:0] px_q, py_q;
  logic signed [VelW-1:0] vx_q, vy_q;
  logic signed [SumW-1:0] px_sum_q, py_sum_q;
  logic        [9:0]      ball_x_q, ball_y_q;
  logic        [1:0]      bounce_q;
  logic                   active_q, done_q, ready_q;

  logic signed [VelW-1:0] vy_grav, vx_res, vy_res;
  logic signed [SumW-1:0] px_sum, py_sum;
  logic        [PosW-1:0] px_res, py_res;
  logic        [1:0]      bounce_res;

  trajectory_step u_step (
    .px_i        (px_q),
    .py_i        (py_q),
    .vx_i        (vx_q),
    .vy_i        (vy_q),
    .vy_grav_o   (vy_grav),
    .px_sum_o    (px_sum),
    .py_sum_o    (py_sum),
    .px_chk_i    (px_sum_q),
    .py_chk_i    (py_sum_q),
    .vx_chk_i    (vx_q),
    .vy_chk_i    (vy_q),
    .bounce_i    (bounce_q),
    .px_res_o    (px_res),
    .py_res_o    (py_res),
    .vx_res_o    (vx_res),
    .vy_res_o    (vy_res),
    .bounce_res_o(bounce_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      px_q     <= PosW'((SCREEN_W / 2) << FRAC);
      py_q     <= PosW'(FloorC << FRAC);
      vx_q     <= '0;
      vy_q     <= '0;
      px_sum_q <= '0;
      py_sum_q <= '0;
      ball_x_q <= 10'(SCREEN_W / 2);
      ball_y_q <= 10'(FloorC);
      bounce_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Launch takes precedence; abort has no meaning here.
          if (launch_valid_i) begin
            state_q  <= StArmed;
            px_q     <= {launch_x_i, {FRAC{1'b0}}};
            py_q     <= {launch_y_i, {FRAC{1'b0}}};
            vx_q     <= {{(VelW-8){launch_vx_i[7]}}, launch_vx_i};
            vy_q     <= {{(VelW-8){launch_vy_i[7]}}, launch_vy_i};
            bounce_q <= '0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        StArmed: begin
          if (abort_i) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            active_q <= 1'b0;
          end else if (frame_tick_i) begin
            state_q <= StUpdate;
          end
        end
        StUpdate: begin
          if (abort_i) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            active_q <= 1'b0;
          end else begin
            state_q  <= StCheck;
            vy_q     <= vy_grav;
            px_sum_q <= px_sum;
            py_sum_q <= py_sum;
          end
        end
        StCheck: begin
          if (abort_i) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            active_q <= 1'b0;
          end else begin
            px_q     <= px_res;
            py_q     <= py_res;
            vx_q     <= vx_res;
            vy_q     <= vy_res;
            bounce_q <= bounce_res;
            ball_x_q <= px_res[PosW-1:FRAC];
            ball_y_q <= py_res[PosW-1:FRAC];
            if (bounce_res == 2'(MAX_BOUNCES)) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              active_q <= 1'b0;
            end else begin
              state_q <= StArmed;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign launch_ready_o = ready_q;
  assign ball_x_o       = ball_x_q;
  assign ball_y_o       = ball_y_q;
  assign ball_active_o  = active_q;
  assign bounce_count_o = bounce_q;
  assign shot_done_o    = done_q;

endmodule

// File: tb/tb_ball_trajectory.sv
// Directed bench for ball_trajectory: launch, gravity, bounces, walls, abort,
// tick filtering and mid-shot reset, against hand-computed values.
module tb_ball_trajectory;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       launch_valid = 1'b0;
  logic       launch_ready;
  logic [9:0] launch_x = '0;
  logic [9:0] launch_y = '0;
  logic [7:0] launch_vx = '0;
  logic [7:0] launch_vy = '0;
  logic       abort = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic       ball_active;
  logic [1:0] bounce_count;
  logic       shot_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_pulses = 0;
  int pulses_before;

  always #20 clk = ~clk;

  always @(posedge clk) if (shot_done === 1'b1) done_pulses <= done_pulses + 1;

  ball_trajectory dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .frame_tick_i  (frame_tick),
    .launch_valid_i(launch_valid),
    .launch_ready_o(launch_ready),
    .launch_x_i    (launch_x),
    .launch_y_i    (launch_y),
    .launch_vx_i   (launch_vx),
    .launch_vy_i   (launch_vy),
    .abort_i       (abort),
    .ball_x_o      (ball_x),
    .ball_y_o      (ball_y),
    .ball_active_o (ball_active),
    .bounce_count_o(bounce_count),
    .shot_done_o   (shot_done)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] x, input logic [9:0] y,
                        input logic [7:0] vx, input logic [7:0] vy);
    launch_valid = 1'b1;
    launch_x     = x;
    launch_y     = y;
    launch_vx    = vx;
    launch_vy    = vy;
    @(negedge clk);
    launch_valid = 1'b0;
  endtask

  // Tick, then wait until the 2-cycle update is visible.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic abort_shot();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ball_x", ball_x, 320);
    chk("rst_ball_y", ball_y, 466);
    chk("rst_ready", launch_ready, 1);
    chk("rst_active", ball_active, 0);
    chk("rst_bounce", bounce_count, 0);
    chk("rst_done", shot_done, 0);

    // Launch up and to the right; outputs wait for the first tick
    launch(10'd100, 10'd400, 8'sd32, -8'sd64);
    chk("l1_ready", launch_ready, 0);
    chk("l1_active", ball_active, 1);
    chk("l1_x_held", ball_x, 320);
    tick();
    chk("l1_x", ball_x, 102);
    chk("l1_y", ball_y, 396);
    chk("l1_vy", dut.vy_q, -58);

    // Abort in ARMED with a simultaneous launch request
    pulses_before = done_pulses;
    abort = 1'b1;
    launch_valid = 1'b1;
    launch_x = 10'd7;
    launch_y = 10'd7;
    @(negedge clk);
    abort = 1'b0;
    launch_valid = 1'b0;
    chk("ab_done", shot_done, 1);
    chk("ab_x", ball_x, 102);
    chk("ab_y", ball_y, 396);
    @(negedge clk);
    chk("ab_done_low", shot_done, 0);
    chk("ab_ready", launch_ready, 1);
    chk("ab_active", ball_active, 0);
    @(negedge clk);
    chk("ab_not_relaunched", ball_active, 0);
    chk("ab_pulses", done_pulses - pulses_before, 1);

    // Drop onto the floor: bounces on ticks 1, 17 and 24
    pulses_before = done_pulses;
    launch(10'd300, 10'd460, 8'sd0, 8'sd96);
    tick();
    chk("dr_y1", ball_y, 466);
    chk("dr_b1", bounce_count, 1);
    chk("dr_vy1", dut.vy_q, -51);
    tick();
    chk("dr_y2", ball_y, 463);
    for (int i = 3; i <= 23; i++) begin
      tick();
      if (i == 17) begin
        chk("dr_b2", bounce_count, 2);
        chk("dr_y17", ball_y, 466);
        chk("dr_vy17", dut.vy_q, -22);
      end
    end
    chk("dr_active23", ball_active, 1);
    chk("dr_pre_done", done_pulses - pulses_before, 0);
    tick();
    chk("dr_b3", bounce_count, 3);
    chk("dr_done", shot_done, 1);
    chk("dr_active", ball_active, 0);
    chk("dr_y_end", ball_y, 466);
    repeat (2) @(negedge clk);
    chk("dr_ready", launch_ready, 1);
    chk("dr_pulses", done_pulses - pulses_before, 1);

    // Left wall and ceiling in the same frame
    launch(10'd5, 10'd2, -8'sd32, -8'sd100);
    tick();
    chk("lw_x", ball_x, 4);
    chk("lw_vx", dut.vx_q, 32);
    chk("ce_y", ball_y, 0);
    chk("ce_vy", dut.vy_q, -94);
    abort_shot();

    // Right wall
    launch(10'd630, 10'd200, 8'sd127, 8'sd0);
    tick();
    chk("rw_x", ball_x, 635);
    chk("rw_vx", dut.vx_q, -127);
    chk("rw_y", ball_y, 200);
    tick();
    chk("rw_x2", ball_x, 627);
    chk("rw_y2", ball_y, 201);

    // Second tick one cycle after the first is dropped
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("dt_x", ball_x, 619);
    chk("dt_y", ball_y, 202);

    // Asynchronous reset mid-shot
    pulses_before = done_pulses;
    rst_n = 1'b0;
    #1;
    chk("mr_x", ball_x, 320);
    chk("mr_y", ball_y, 466);
    chk("mr_active", ball_active, 0);
    chk("mr_ready", launch_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_bounce", bounce_count, 0);
    chk("mr_done", shot_done, 0);
    chk("mr_pulses", done_pulses - pulses_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
